// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - control FSM sequencing fetch/decode/operand/memory cycles
// for the 8-bit accumulator datapath; every datapath strobe is decoded from state and IR.
module cpu_controller #(
  parameter bit ENABLE_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic       Aeq0,
  input  logic       apos,
  output logic       IRload,
  output logic       PCload,
  output logic       MemInst,
  output logic       MRload,
  output logic       memWr,
  output logic       Aload,
  output logic       RFwr,
  output logic       outen,
  output logic [1:0] JMPmux,
  output logic [2:0] Asel,
  output logic [2:0] ALUsel,
  output logic [1:0] Shftsel,
  output logic       halted,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    s_fetch  = 3'd0,
    s_decode = 3'd1,
    s_oper   = 3'd2,
    s_mem    = 3'd3,
    s_halt   = 3'd4
  } state_t;

  localparam logic [3:0] op_sys = 4'h0;
  localparam logic [3:0] op_lda = 4'h1;
  localparam logic [3:0] op_sta = 4'h2;
  localparam logic [3:0] op_ldm = 4'h3;
  localparam logic [3:0] op_stm = 4'h4;
  localparam logic [3:0] op_jmp = 4'h5;
  localparam logic [3:0] op_jz  = 4'h6;
  localparam logic [3:0] op_jp  = 4'h7;

  localparam logic [2:0] asel_shift  = 3'd0;
  localparam logic [2:0] asel_regf   = 3'd1;
  localparam logic [2:0] asel_input  = 3'd2;
  localparam logic [2:0] asel_memout = 3'd3;

  localparam logic [1:0] pc_inc  = 2'b00;
  localparam logic [1:0] pc_abs  = 2'b01;

  state_t state;
  state_t next_state;

  logic [3:0] op;
  logic [3:0] sub;
  logic       dir;
  logic       is_two_byte;
  logic       is_hlt;

  assign op          = IR[7:4];
  assign sub         = IR[3:0];
  assign dir         = IR[3];
  assign is_two_byte = (op == op_ldm) || (op == op_stm) || (op == op_jmp);
  assign is_hlt      = (op == op_sys) && (sub == 4'b0011);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= s_fetch;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = s_fetch;
    case (state)
      s_fetch: next_state = s_decode;
      s_decode: begin
        if (is_two_byte) begin
          next_state = s_oper;
        end else if (is_hlt && ENABLE_HALT) begin
          next_state = s_halt;
        end else begin
          next_state = s_fetch;
        end
      end
      s_oper: begin
        if ((op == op_ldm) || (op == op_stm)) begin
          next_state = s_mem;
        end else begin
          next_state = s_fetch;
        end
      end
      s_mem:   next_state = s_fetch;
      s_halt:  next_state = s_halt;
      default: next_state = s_fetch;
    endcase
  end

  // Outputs are held at zero for the whole time reset is high, not just after the edge.
  always_comb begin
    IRload    = 1'b0;
    PCload    = 1'b0;
    MemInst   = 1'b0;
    MRload    = 1'b0;
    memWr     = 1'b0;
    Aload     = 1'b0;
    RFwr      = 1'b0;
    outen     = 1'b0;
    JMPmux    = pc_inc;
    Asel      = asel_shift;
    ALUsel    = 3'b000;
    Shftsel   = 2'b00;
    halted    = 1'b0;
    state_dbg = 3'd0;
    if (!reset) begin
      state_dbg = state;
      case (state)
        s_fetch: begin
          IRload = 1'b1;
          PCload = 1'b1;
        end
        s_decode: begin
          case (op)
            op_sys: begin
              if (sub == 4'b0001) begin
                Asel  = asel_input;
                Aload = 1'b1;
              end else if (sub == 4'b0010) begin
                outen = 1'b1;
              end else if (sub[3:2] == 2'b01) begin
                Shftsel = sub[1:0];
                Aload   = 1'b1;
              end
            end
            op_lda: begin
              Asel  = asel_regf;
              Aload = 1'b1;
            end
            op_sta: RFwr = 1'b1;
            // Relative targets are taken from the PC already bumped in FETCH.
            op_jz: begin
              if (Aeq0) begin
                PCload = 1'b1;
                JMPmux = {1'b1, ~dir};
              end
            end
            op_jp: begin
              if (apos) begin
                PCload = 1'b1;
                JMPmux = {1'b1, ~dir};
              end
            end
            default: begin
              if (op[3]) begin
                ALUsel = op[2:0];
                Aload  = 1'b1;
              end
            end
          endcase
        end
        s_oper: begin
          if (op == op_jmp) begin
            PCload = 1'b1;
            JMPmux = pc_abs;
          end else if ((op == op_ldm) || (op == op_stm)) begin
            MRload = 1'b1;
            PCload = 1'b1;
          end
        end
        s_mem: begin
          MemInst = 1'b1;
          if (op == op_ldm) begin
            Asel  = asel_memout;
            Aload = 1'b1;
          end else if (op == op_stm) begin
            memWr = 1'b1;
          end
        end
        s_halt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control FSM for the accumulator datapath: the other end of the datapath control/status interface.
- Consumes IR, Aeq0 and apos; drives every datapath load, select and write strobe.
- Sequences fetch, decode/execute, operand fetch and memory access for an 8-bit ISA with a 6-bit address space.
- Sits beside the datapath inside the CPU top level; one controller per datapath.

Parameters:
- ENABLE_HALT, 1: 1 = HLT enters HALT; 0 = HLT decodes as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IR  in  8  instruction register contents from the datapath.
- Aeq0  in  1  accumulator == 0.
- apos  in  1  accumulator bit7 == 0.
- IRload, PCload, MemInst, MRload, memWr, Aload, RFwr, outen  out  1 each  datapath strobes.
- JMPmux  out  2  PC source: 00 PC+1, 01 memout[5:0], 10 PC-IR[2:0], 11 PC+IR[2:0].
- Asel  out  3  acc source: 0 shifter, 1 regfile, 2 inext, 3 memout.
- ALUsel  out  3  ALU op (000 = pass A).
- Shftsel  out  2  shifter op (00 = pass).
- halted  out  1  high in HALT.
- state_dbg  out  3  encoded state: FETCH=0, DECODE=1, OPER=2, MEM=3, HALT=4.

Behaviour:
- Datapath contract:
  - RAM read is combinational from RAMaddr; RAM write, IR, PC, MR, acc, regfile and out-reg updates occur on the clk edge their strobe is high.
- Decode fields:
  - op = IR[7:4]; r/offset = IR[2:0]; dir = IR[3] (1 = backward).
- Opcode map:
  - 0x0 sub-ops on IR[3:0]: 0000 NOP, 0001 IN, 0010 OUT, 0011 HLT, 01ss SHF (ss = Shftsel), 1xxx NOP.
  - 0x1 LDA r; 0x2 STA r; 0x3 LDM addr; 0x4 STM addr; 0x5 JMP addr; 0x6 JZ ±off; 0x7 JP ±off.
  - 0x8-0xF ALU: ALUsel = IR[6:4], operand R[r], result through shifter with Shftsel=00.
  - LDM, STM and JMP are two bytes; the second byte is the address.
- Output rules:
  - All outputs are combinational from state and IR.
  - Any strobe not listed for a state is 0; JMPmux, Asel, ALUsel and Shftsel default to 0.
- FETCH:
  - MemInst=0, IRload=1, PCload=1, JMPmux=00.
  - Next state: DECODE.
- DECODE executes single-cycle ops, then returns to FETCH:
  - LDA: Asel=1, Aload.
  - STA: RFwr.
  - IN: Asel=2, Aload.
  - OUT: outen.
  - SHF: ALUsel=000, Asel=0, Aload.
  - ALU: Asel=0, Aload.
  - JZ: if Aeq0, PCload with JMPmux={1,~dir}; else nothing.
  - JP: if apos, same as JZ; else nothing.
  - Relative jumps are relative to the already-incremented PC.
  - HLT (ENABLE_HALT=1): next state HALT.
  - LDM, STM, JMP: next state OPER.
- OPER:
  - MemInst=0, reading the operand byte at PC.
  - JMP: PCload, JMPmux=01, then FETCH.
  - LDM/STM: MRload, PCload, JMPmux=00, then MEM.
- MEM:
  - MemInst=1.
  - LDM: Asel=3, Aload.
  - STM: memWr.
  - Next state: FETCH.
- HALT:
  - All strobes 0, halted=1.
  - Held until reset.
- Latency:
  - 2 cycles for single-cycle ops and for JZ/JP, taken or not.
  - JMP 3 cycles; LDM/STM 4 cycles.
- PC arithmetic wraps modulo 64 in the datapath; the controller places no limit on it.
- Reset:
  - While reset is high: state=FETCH and every output is forced to 0, including IRload, PCload and halted.
  - Asserting reset mid-instruction aborts it at once; no partial memWr, RFwr or Aload occurs after assertion.
  - The first FETCH strobes appear in the first cycle after reset deasserts.
- Unused state encodings go to FETCH on the next edge with all strobes 0.

Test Plan:
- Reset, then mem[0]=0x80|0x00 (ADD R0 with ALUsel=000), IR driven accordingly → state_dbg 0,1,0; Aload=1 and Asel=0 only in DECODE; reset mid-DECODE forces Aload=0 immediately.
- IR=0x30, mem operand=0x2A → FETCH, DECODE, OPER (MRload=1, PCload=1, JMPmux=00), MEM (MemInst=1, Asel=3, Aload=1), then FETCH; STM 0x40 gives memWr=1 only in MEM.
- IR=0x50, operand 0x15 → OPER asserts PCload=1 with JMPmux=01; next state FETCH; total 3 cycles.
- IR=0x6B (JZ back 3):
  - Aeq0=1 → DECODE asserts PCload=1, JMPmux=10.
  - Aeq0=0 → PCload=0.
  - IR=0x73 with apos=1 → JMPmux=11.
- IR=0x06 (SHF 10) → ALUsel=000, Shftsel=10, Asel=0, Aload=1; IR=0x01 → Asel=2, Aload=1; IR=0x02 → outen=1, Aload=0.
- IR=0x03 with ENABLE_HALT=1 → HALT, halted=1, all strobes 0 for 20 cycles, recovers only on reset; with ENABLE_HALT=0 → NOP, back to FETCH.
